// File: rtl/alu_result_collector.sv
// alu_result_collector: gathers the four ALU unit results, normalises the
// active one to a widthart-bit word and queues it in a small circular FIFO
// drained over a valid/ready handshake. Collisions and overflow are latched
// as sticky errors and counted in a saturating drop counter.
module alu_result_collector #(
  parameter int widtha   = 16,
  parameter int widthart = 32,
  parameter int DEPTH    = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [widthart-1:0]        arith_out,
  input  logic [widtha-1:0]          logic_out,
  input  logic [widtha-1:0]          cmp_out,
  input  logic [widtha-1:0]          shift_out,
  input  logic                       arith_flag,
  input  logic                       logic_flag,
  input  logic                       cmp_flag,
  input  logic                       shift_flag,
  input  logic                       carry_out,
  input  logic                       out_ready,
  input  logic                       err_clr,
  output logic                       out_valid,
  output logic [widthart-1:0]        out_data,
  output logic [1:0]                 out_unit,
  output logic                       out_carry,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       err_multi,
  output logic                       err_ovf,
  output logic [7:0]                 drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = widthart + 3;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  // Entry layout: {unit[1:0], carry, data}
  logic [EW-1:0]       mem_r [DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [LW-1:0]       level_r;
  logic                err_multi_r;
  logic                err_ovf_r;
  logic [7:0]          drop_cnt_r;

  logic [2:0]          flag_cnt_s;
  logic [EW-1:0]       entry_s;
  logic [EW-1:0]       head_s;
  logic                one_hot_s;
  logic                multi_s;
  logic                full_s;
  logic                pop_s;
  logic                push_s;
  logic                ovf_s;
  logic                drop_s;

  // Count active flags and build the normalised entry for the single active unit.
  always_comb begin
    flag_cnt_s = 3'(arith_flag) + 3'(logic_flag) + 3'(cmp_flag) + 3'(shift_flag);
    entry_s    = {EW{1'b0}};
    if (arith_flag) begin
      entry_s = {2'b00, carry_out, arith_out};
    end else if (logic_flag) begin
      entry_s = {2'b01, 1'b0, {(widthart-widtha){1'b0}}, logic_out};
    end else if (cmp_flag) begin
      entry_s = {2'b10, 1'b0, {(widthart-widtha){1'b0}}, cmp_out};
    end else if (shift_flag) begin
      entry_s = {2'b11, 1'b0, {(widthart-widtha){1'b0}}, shift_out};
    end else begin
      entry_s = {EW{1'b0}};
    end
  end

  // Decide push/pop/drop for this cycle; a full FIFO still accepts when it pops.
  always_comb begin
    one_hot_s = (flag_cnt_s == 3'd1);
    multi_s   = (flag_cnt_s > 3'd1);
    full_s    = (level_r == DEPTH_L);
    pop_s     = (level_r != {LW{1'b0}}) && out_ready;
    push_s    = one_hot_s && (!full_s || pop_s);
    ovf_s     = one_hot_s && full_s && !pop_s;
    drop_s    = multi_s || ovf_s;
  end

  // Write accepted entries into storage; contents need no reset.
  always_ff @(posedge CLK) begin
    if (!RST && push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // Advance pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky errors and saturating drop counter; a new error beats err_clr.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_multi_r <= 1'b0;
      err_ovf_r   <= 1'b0;
      drop_cnt_r  <= 8'd0;
    end else if (err_clr) begin
      err_multi_r <= multi_s;
      err_ovf_r   <= ovf_s;
      drop_cnt_r  <= drop_s ? 8'd1 : 8'd0;
    end else begin
      err_multi_r <= err_multi_r | multi_s;
      err_ovf_r   <= err_ovf_r | ovf_s;
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  // Present the head entry through the read-pointer mux, zeroed when empty.
  always_comb begin
    head_s    = mem_r[rd_ptr_r];
    out_valid = (level_r != {LW{1'b0}});
    if (out_valid) begin
      out_unit  = head_s[EW-1:EW-2];
      out_carry = head_s[widthart];
      out_data  = head_s[widthart-1:0];
    end else begin
      out_unit  = 2'b00;
      out_carry = 1'b0;
      out_data  = {widthart{1'b0}};
    end
  end

  assign fifo_level = level_r;
  assign err_multi  = err_multi_r;
  assign err_ovf    = err_ovf_r;
  assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: hand-computed expectations checked
// with immediate assertions one cycle-step at a time.
module tb_alu_result_collector;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] arith_out;
  logic [15:0] logic_out, cmp_out, shift_out;
  logic        arith_flag, logic_flag, cmp_flag, shift_flag;
  logic        carry_out, out_ready, err_clr;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_unit;
  logic        out_carry;
  logic [2:0]  fifo_level;
  logic        err_multi, err_ovf;
  logic [7:0]  drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_result_collector #(.widtha(16), .widthart(32), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .carry_out(carry_out), .out_ready(out_ready), .err_clr(err_clr),
    .out_valid(out_valid), .out_data(out_data), .out_unit(out_unit), .out_carry(out_carry),
    .fifo_level(fifo_level), .err_multi(err_multi), .err_ovf(err_ovf), .drop_cnt(drop_cnt)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_flags();
    arith_flag = 1'b0; logic_flag = 1'b0; cmp_flag = 1'b0; shift_flag = 1'b0;
    carry_out  = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] d, input logic [1:0] u, input logic c);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"},  64'(out_data),  64'(d));
    chk({tag, "_unit"},  64'(out_unit),  64'(u));
    chk({tag, "_carry"}, 64'(out_carry), 64'(c));
  endtask

  initial begin
    RST = 1'b1; err_clr = 1'b0; out_ready = 1'b0;
    arith_out = 32'd0; logic_out = 16'd0; cmp_out = 16'd0; shift_out = 16'd0;
    clr_flags();
    tick(); tick();
    RST = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_data",  64'(out_data), 64'd0);
    chk("rst_unit",  64'(out_unit), 64'd0);
    chk("rst_carry", 64'(out_carry), 64'd0);
    chk("rst_multi", 64'(err_multi), 64'd0);
    chk("rst_ovf",   64'(err_ovf), 64'd0);
    chk("rst_drop",  64'(drop_cnt), 64'd0);

    // Single arith push onto empty FIFO with out_ready already high.
    out_ready = 1'b1; arith_flag = 1'b1; arith_out = 32'hFFFF_FFF0; carry_out = 1'b1;
    tick(); clr_flags();
    chk_head("arith1", 32'hFFFF_FFF0, 2'b00, 1'b1);
    chk("arith1_level", 64'(fifo_level), 64'd1);
    tick();
    chk("arith1_popped_valid", 64'(out_valid), 64'd0);
    chk("arith1_popped_level", 64'(fifo_level), 64'd0);
    chk("arith1_popped_data",  64'(out_data), 64'd0);

    // Fill with four different units while the consumer stalls.
    out_ready = 1'b0;
    logic_flag = 1'b1; logic_out = 16'h00A5; tick(); clr_flags();
    cmp_flag = 1'b1;   cmp_out = 16'h0001;   tick(); clr_flags();
    shift_flag = 1'b1; shift_out = 16'h8000; tick(); clr_flags();
    arith_flag = 1'b1; arith_out = 32'h7; carry_out = 1'b0; tick(); clr_flags();
    chk("fill_level", 64'(fifo_level), 64'd4);
    chk_head("fill_head", 32'h0000_00A5, 2'b01, 1'b0);
    tick();
    chk_head("fill_hold", 32'h0000_00A5, 2'b01, 1'b0);
    out_ready = 1'b1;
    chk_head("drain0", 32'h0000_00A5, 2'b01, 1'b0); tick();
    chk_head("drain1", 32'h0000_0001, 2'b10, 1'b0); tick();
    chk_head("drain2", 32'h0000_8000, 2'b11, 1'b0); tick();
    chk_head("drain3", 32'h0000_0007, 2'b00, 1'b0); tick();
    chk("drain_empty_level", 64'(fifo_level), 64'd0);
    chk("drain_empty_valid", 64'(out_valid), 64'd0);

    // Overflow: full FIFO, no pop -> drop; then full with pop -> accepted.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      arith_flag = 1'b1; arith_out = 32'(i); tick(); clr_flags();
    end
    chk("full_level", 64'(fifo_level), 64'd4);
    logic_flag = 1'b1; logic_out = 16'h0055; tick(); clr_flags();
    chk("ovf_bit",   64'(err_ovf), 64'd1);
    chk("ovf_drop",  64'(drop_cnt), 64'd1);
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_multi", 64'(err_multi), 64'd0);
    chk_head("ovf_head", 32'h1, 2'b00, 1'b0);
    out_ready = 1'b1; logic_flag = 1'b1; logic_out = 16'h0066; tick(); clr_flags();
    out_ready = 1'b0;
    chk("fullpop_level", 64'(fifo_level), 64'd4);
    chk("fullpop_drop",  64'(drop_cnt), 64'd1);
    chk_head("fullpop_head", 32'h2, 2'b00, 1'b0);
    out_ready = 1'b1;
    chk_head("fp_drain0", 32'h2, 2'b00, 1'b0); tick();
    chk_head("fp_drain1", 32'h3, 2'b00, 1'b0); tick();
    chk_head("fp_drain2", 32'h4, 2'b00, 1'b0); tick();
    chk_head("fp_drain3", 32'h66, 2'b01, 1'b0); tick();
    chk("fp_empty", 64'(fifo_level), 64'd0);
    out_ready = 1'b0;

    // Clear, then collision, clear, and collision concurrent with clear.
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr1_ovf",  64'(err_ovf), 64'd0);
    chk("clr1_drop", 64'(drop_cnt), 64'd0);
    arith_flag = 1'b1; cmp_flag = 1'b1; tick(); clr_flags();
    chk("multi_bit",   64'(err_multi), 64'd1);
    chk("multi_drop",  64'(drop_cnt), 64'd1);
    chk("multi_level", 64'(fifo_level), 64'd0);
    chk("multi_valid", 64'(out_valid), 64'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr2_multi", 64'(err_multi), 64'd0);
    chk("clr2_drop",  64'(drop_cnt), 64'd0);
    tick(); tick();
    err_clr = 1'b1; logic_flag = 1'b1; shift_flag = 1'b1; tick(); err_clr = 1'b0; clr_flags();
    chk("clrwin_multi", 64'(err_multi), 64'd1);
    chk("clrwin_drop",  64'(drop_cnt), 64'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Saturation of the drop counter.
    arith_flag = 1'b1; logic_flag = 1'b1; cmp_flag = 1'b1; shift_flag = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    chk("sat_254", 64'(drop_cnt), 64'd254);
    for (int i = 0; i < 46; i++) tick();
    clr_flags();
    chk("sat_255", 64'(drop_cnt), 64'd255);
    tick();
    chk("sat_hold", 64'(drop_cnt), 64'd255);

    // Reset mid-stream with three entries held and a flag in the reset cycle.
    for (int i = 0; i < 3; i++) begin
      shift_flag = 1'b1; shift_out = 16'(i + 16'h10); tick(); clr_flags();
    end
    chk("pre_rst_level", 64'(fifo_level), 64'd3);
    RST = 1'b1; arith_flag = 1'b1; arith_out = 32'hDEAD; tick(); RST = 1'b0; clr_flags();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_multi", 64'(err_multi), 64'd0);
    chk("mid_rst_drop",  64'(drop_cnt), 64'd0);
    chk("mid_rst_data",  64'(out_data), 64'd0);
    cmp_flag = 1'b1; cmp_out = 16'hBEEF; tick(); clr_flags();
    chk_head("post_rst", 32'h0000_BEEF, 2'b10, 1'b0);
    chk("post_rst_level", 64'(fifo_level), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Downstream stage of the ALU top level. Consumes the four registered unit results (arithmetic, logic, compare, shift) and their per-unit valid flags, normalises the active result to a common 32-bit word, and buffers it in a small FIFO. Results are presented to the next consumer (register file or bus interface) over a valid/ready handshake, with sticky error reporting for collisions and overflow.

## Interface
- widtha, 16, width of logic/compare/shift results
- widthart, 32, width of arithmetic result and of the output data word
- DEPTH, 4, FIFO entries (power of two, 2..16)

- CLK  input  1  single clock, all state on rising edge
- RST  input  1  reset, synchronous, active-high
- arith_out  input  widthart  signed arithmetic result
- logic_out  input  widtha  logic result
- cmp_out  input  widtha  compare result
- shift_out  input  widtha  shift result
- arith_flag, logic_flag, cmp_flag, shift_flag  input  1 each  result valid for that unit, this cycle
- carry_out  input  1  arithmetic carry, qualified by arith_flag
- out_ready  input  1  consumer accepts head entry
- err_clr  input  1  clears sticky error bits and drop counter
- out_valid  output  1  head entry available
- out_data  output  widthart  head entry data
- out_unit  output  2  source of head entry: 00 arith, 01 logic, 10 cmp, 11 shift
- out_carry  output  1  carry of head entry (0 for non-arith)
- fifo_level  output  $clog2(DEPTH)+1  entries held
- err_multi  output  1  sticky: more than one flag high in one cycle
- err_ovf  output  1  sticky: result arrived with FIFO full and no pop
- drop_cnt  output  8  results discarded, saturating at 255

## Operation
- Push request: exactly one of the four flags high.
- Normalisation: arith_out stored unchanged; logic/cmp/shift zero-extended to widthart. out_carry = carry_out for arith, 0 otherwise.
- Entry = {unit[1:0], carry, data[widthart-1:0]}; circular buffer with wr/rd pointers and occupancy counter.
- Pop: out_valid && out_ready.
- Push accepted when level < DEPTH, or level == DEPTH with a pop in the same cycle.
- Push rejected when full and no pop: entry discarded, err_ovf set, drop_cnt += 1.
- Two or more flags high: nothing pushed, err_multi set, drop_cnt += 1. No flags: no action.
- Simultaneous push and pop: level unchanged; both pointers advance; popped entry is the old head.
- Push and pop on empty FIFO: no pop occurs (out_valid low); push lands, level becomes 1.
- Pointers wrap modulo DEPTH.
- drop_cnt saturates at 255; never wraps.
- err_clr: clears err_multi, err_ovf, drop_cnt next edge; a new error in the same cycle wins (bit set, drop_cnt = 1).
- out_data/out_unit/out_carry hold the head entry while out_valid is high and out_ready is low; stable until pop.
- When empty, out_data/out_unit/out_carry are 0.

## Timing
- Reset (RST high at an edge): pointers, level, out_valid, out_data, out_unit, out_carry, err_multi, err_ovf, drop_cnt all 0. FIFO contents need not be cleared. Reset mid-stream discards all held entries; flags in the reset cycle are ignored.
- Latency: flag sampled at edge N; out_valid high after edge N when FIFO was empty (visible in cycle N+1).
- Pop at edge M: next entry (if any) on outputs after edge M; no bubble.
- Throughput: one push and one pop per cycle.
- fifo_level, err bits, drop_cnt update at the same edge as the causing event.
- Outputs registered or driven from FIFO storage through read-pointer mux only; no combinational path from flags or out_ready to out_valid/out_data.

## Test plan
- Reset then single arith push arith_out=32'hFFFF_FFF0, carry_out=1, out_ready=1 -> next cycle out_valid=1, out_data=FFFF_FFF0, out_unit=00, out_carry=1; following cycle out_valid=0, level=0.
- out_ready=0, push logic 16'h00A5, cmp 16'h0001, shift 16'h8000, arith 32'h7 -> level=4, head out_data=0000_00A5 unit=01 held; raise out_ready -> four pops in order, shift entry out_data=0000_8000.
- Full FIFO, out_ready=0, one more push -> dropped, err_ovf=1, drop_cnt=1, level=4; repeat with out_ready=1 same cycle -> accepted, level stays 4, no new drop.
- arith_flag and cmp_flag high together -> no push, err_multi=1, drop_cnt+1; err_clr pulse -> both 0 next cycle.
- 300 collision cycles -> drop_cnt=255, stays 255.
- Three entries held, RST asserted one cycle -> out_valid=0, level=0, errors 0; push after reset appears normally.
